prio_enc_queue: RTL and testbench
=================================

Name: prio_enc_queue

Overview:
- Parametrised, registered successor to the team's 8-to-3 combinational priority encoder.
- Latches one-cycle request pulses from N sources into a pending register, with per-source masking.
- Presents the selected source index on a valid/ack handshake and holds it stable until consumed.
- Priority mode is fixed (highest index wins) or round-robin; sits between interrupt/event sources and a single consumer such as a CPU's interrupt-cause register.

Parameters:
- N, 8, number of request sources (N >= 2).
- W, $clog2(N), width of the index output; derived, not overridden.
- RR, 0, priority mode: 0 = fixed priority (highest index wins); 1 = round-robin.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request pulses; bit k high for a cycle sets pending[k].
- mask  input  N  bit k high means source k is excluded from selection; its pending bit is retained.
- valid  output  1  an index is presented on id.
- id  output  W  index of the presented source.
- ack  input  1  consumer accepts id; effective only when valid=1.
- idle  output  1  high when no request is pending and valid=0.
- pend  output  N  current pending register, for debug and status reads.

Behaviour:
- Reset (async assert, sync release):
  - pending = 0, valid = 0, id = 0, ptr = N-1, idle = 1.
  - Reset mid-handshake discards all pending requests and the presented id.
- Pending update each edge: pending <= (pending & ~clr) | req.
  - clr is a one-hot at id when valid & ack, otherwise 0.
  - Set wins over clear: if req[id] is high in the ack cycle, pending[id] stays 1.
- Candidate set: cand = pending & ~mask & ~clr. The same-cycle req is not included, because pending is registered first.
- Pick, when cand != 0:
  - Search descending from ptr down to 0, then wrap from N-1 down to ptr+1; the first set bit is chosen.
  - RR=0: ptr is constant N-1, giving a pure highest-index-wins encoder.
  - RR=1: on each accepted ack of index k, ptr <= (k==0) ? N-1 : k-1, so k becomes lowest priority.
- Output register load:
  - Load occurs when valid==0, or when valid & ack.
  - If cand != 0 on a load edge: valid <= 1 and id <= pick.
  - Else: valid <= 0 and id keeps its last value.
- Hold rule:
  - While valid=1 and ack=0, id and valid are frozen.
  - A higher-priority request arriving in that window does not pre-empt.
  - Masking the presented source after presentation does not withdraw it.
- Latency:
  - req at edge E0 sets pending at E0.
  - valid/id update at E1, i.e. one cycle after the pending bit is visible.
- Back-to-back: with ack held high, a new index can be presented every cycle. There is no bubble when cand != 0 at the ack edge.
- ack while valid=0 is ignored: no clear, no ptr change.
- idle = ~valid & (pending == 0), decoded from registers with no combinational path from inputs.
  - Masked pending bits keep idle=0.
- Sources held high on req re-pend every cycle. Level-sensitive use is permitted, but the source is re-presented after each ack.

Decomposition:
- Shared package:
  - Mode constants PRIO_FIXED=0 and PRIO_RR=1.
  - A helper function for the index width.
- Sub-module prio_pick:
  - Combinational rotating priority picker.
  - Inputs: cand[N], ptr[W]. Outputs: any, idx[W].
  - Implemented as a doubled-vector descending scan.
  - Reused by the future vectored-interrupt controller.
- The top level holds the pending register, the output/handshake register and ptr.

Test Plan:
- Reset, then idle bench: after rst_n release with req=0 for 5 cycles -> valid=0, id=0, idle=1, pend=0.
- Fixed priority, N=8, RR=0: req=8'h24 for one cycle -> next edge id=5, valid=1. After ack -> id=2. After a second ack -> valid=0, idle=1.
- Hold/no-preempt: id=2 presented with ack=0, then req[7] pulsed -> id remains 2 until ack. The following cycle presents id=7.
- Round-robin, RR=1: req=8'hFF once, ack held high -> ids 7,6,5,4,3,2,1,0 on consecutive cycles. Then valid=0.
- Round-robin fairness, RR=1: after ack of 7, req[7] re-pulsed alongside pending 3 and 6 -> order 6, 3, 7.
- Mask and set-wins-clear: mask=8'h80 with req[7] pending -> valid=0, idle=0. Clearing the mask -> id=7. Acking id 7 while req[7]=1 -> pend[7] stays 1 and id=7 is re-presented next cycle.
- Async reset mid-handshake: rst_n asserted low asynchronously while valid=1 with pend=8'h0C -> outputs clear immediately to valid=0, pend=0, idle=1.

Source files
------------

// File: rtl/prio_enc_queue_pkg.sv
// Shared constants and helpers for the registered priority-encoder queue
// and its rotating picker.
package prio_enc_queue_pkg;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    // Index width for n sources; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_enc_queue_if.sv
// Request/selection bus between event sources, the encoder and its consumer.
interface prio_enc_queue_if
    import prio_enc_queue_pkg::*;
#(
    parameter int N = 8
);
    localparam int W = idx_w(N);

    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         ack;
    logic         valid;
    logic [W-1:0] id;
    logic         idle;
    logic [N-1:0] pend;

    // master: sources + consumer side; slave: the encoder
    modport master (output req, mask, ack, input valid, id, idle, pend);
    modport slave  (input req, mask, ack, output valid, id, idle, pend);

endinterface

// File: rtl/prio_enc_queue_pick.sv
// Combinational rotating priority picker: scans descending from ptr, wrapping
// from N-1 back down to ptr+1, and returns the first set candidate.
module prio_pick
    import prio_enc_queue_pkg::*;
#(
    parameter int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] i_cand,
    input  logic [W-1:0] i_ptr,
    output logic         o_any,
    output logic [W-1:0] o_idx
);

    logic [2*N-1:0] w_dbl;
    logic           w_found;
    int             w_pos;

    // Doubling the vector turns the wrapped search into one straight
    // descending scan over bits ptr+N down to ptr+1.
    assign w_dbl = {i_cand, i_cand};
    assign o_any = |i_cand;

    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int j = 0; j < N; j++) begin
            w_pos = int'(i_ptr) + N - j;
            if (!w_found && w_dbl[w_pos]) begin
                w_found = 1'b1;
                o_idx   = W'((w_pos >= N) ? (w_pos - N) : w_pos);
            end
        end
    end

endmodule

// File: rtl/prio_enc_queue.sv
// Registered priority-encoder queue: latches request pulses, presents one
// selected index on a valid/ack handshake and holds it until consumed.
module prio_enc_queue
    import prio_enc_queue_pkg::*;
#(
    parameter int N  = 8,
    parameter int RR = PRIO_FIXED
) (
    input  logic            clk,
    input  logic            rst_n,
    prio_enc_queue_if.slave bus
);

    localparam int W = idx_w(N);
    localparam logic [W-1:0] PTR_TOP = W'(N - 1);

    logic [N-1:0] r_pend;
    logic         r_valid;
    logic [W-1:0] r_id;
    logic [W-1:0] r_ptr;

    logic         w_fire;
    logic         w_load;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_cand;
    logic         w_any;
    logic [W-1:0] w_idx;

    // ack only counts against a presented index
    assign w_fire = r_valid & bus.ack;
    assign w_load = ~r_valid | w_fire;
    assign w_clr  = w_fire ? ({{(N-1){1'b0}}, 1'b1} << r_id) : '0;

    // The index being consumed this edge must not be picked again, even if
    // its source re-pulses; the re-pend is seen one cycle later.
    assign w_cand = r_pend & ~bus.mask & ~w_clr;

    prio_pick #(.N(N)) u_pick (
        .i_cand (w_cand),
        .i_ptr  (r_ptr),
        .o_any  (w_any),
        .o_idx  (w_idx)
    );

    // Set wins over clear for a source re-pulsing in its own ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pend <= '0;
        else        r_pend <= (r_pend & ~w_clr) | bus.req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_id    <= '0;
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) r_id <= w_idx;
        end
    end

    // Round-robin: the just-accepted index drops to lowest priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= PTR_TOP;
        end else if (RR == PRIO_RR && w_fire) begin
            r_ptr <= (r_id == '0) ? PTR_TOP : (r_id - 1'b1);
        end
    end

    assign bus.valid = r_valid;
    assign bus.id    = r_id;
    assign bus.pend  = r_pend;
    assign bus.idle  = ~r_valid & ~|r_pend;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Bench for prio_enc_queue: a fixed-priority and a round-robin instance share
// directed stimulus; a queue-level model is compared every cycle.
module tb_prio_enc_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    prio_enc_queue_if #(.N(8)) bus0 ();
    prio_enc_queue_if #(.N(8)) bus1 ();

    assign bus0.req = req;  assign bus0.mask = mask;  assign bus0.ack = ack;
    assign bus1.req = req;  assign bus1.mask = mask;  assign bus1.ack = ack;

    prio_enc_queue #(.N(8), .RR(0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    prio_enc_queue #(.N(8), .RR(1)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    typedef struct {
        logic [7:0] pend;
        logic       vld;
        logic [2:0] id;
        int         ptr;
    } mstate_t;

    mstate_t ms0, ms1;

    // Model: the search order is ptr, ptr-1, ..., 0, 7, ..., ptr+1 over what
    // is pending, unmasked and not being consumed right now.
    function automatic mstate_t mnext(input bit rr, input mstate_t s,
                                      input logic [7:0] rq, input logic [7:0] mk,
                                      input logic ak);
        mstate_t    n;
        logic [7:0] cand;
        bit         fire;
        bit         found;
        int         c;
        n     = s;
        fire  = s.vld && ak;
        found = 0;
        cand  = s.pend & ~mk;
        if (fire) begin
            cand[s.id]   = 1'b0;
            n.pend[s.id] = 1'b0;
        end
        n.pend = n.pend | rq;
        if (rr && fire) n.ptr = (int'(s.id) + 7) % 8;
        if (!s.vld || fire) begin
            n.vld = 1'b0;
            for (int k = 0; k < 8; k++) begin
                c = (s.ptr - k + 8) % 8;
                if (!found && cand[c]) begin
                    found = 1;
                    n.vld = 1'b1;
                    n.id  = 3'(c);
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms0 <= '{pend: 8'h00, vld: 1'b0, id: 3'd0, ptr: 7};
            ms1 <= '{pend: 8'h00, vld: 1'b0, id: 3'd0, ptr: 7};
        end else begin
            ms0 <= mnext(1'b0, ms0, req, mask, ack);
            ms1 <= mnext(1'b1, ms1, req, mask, ack);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("cmp_fix_valid", 32'(bus0.valid), 32'(ms0.vld));
            chk("cmp_fix_id",    32'(bus0.id),    32'(ms0.id));
            chk("cmp_fix_pend",  32'(bus0.pend),  32'(ms0.pend));
            chk("cmp_fix_idle",  32'(bus0.idle),  32'(!ms0.vld && ms0.pend == 8'h00));
            chk("cmp_rr_valid",  32'(bus1.valid), 32'(ms1.vld));
            chk("cmp_rr_id",     32'(bus1.id),    32'(ms1.id));
            chk("cmp_rr_pend",   32'(bus1.pend),  32'(ms1.pend));
            chk("cmp_rr_idle",   32'(bus1.idle),  32'(!ms1.vld && ms1.pend == 8'h00));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Literal check of valid and id on both instances.
    task automatic both(input string nm, input logic v, input logic [2:0] fid, input logic [2:0] rid);
        chk({nm, "_fix_v"},  32'(bus0.valid), 32'(v));
        chk({nm, "_rr_v"},   32'(bus1.valid), 32'(v));
        if (v) begin
            chk({nm, "_fix_id"}, 32'(bus0.id), 32'(fid));
            chk({nm, "_rr_id"},  32'(bus1.id), 32'(rid));
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mask = '0; ack = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // reset / idle
        repeat (5) cyc();
        chk("rst_valid", 32'(bus0.valid), 32'd0);
        chk("rst_id",    32'(bus0.id),    32'd0);
        chk("rst_idle",  32'(bus0.idle),  32'd1);
        chk("rst_pend",  32'(bus0.pend),  32'd0);
        chk("rst_rr_idle", 32'(bus1.idle), 32'd1);

        // fixed priority basic: 0x24 -> 5 then 2 then empty
        req = 8'h24; cyc();
        req = 8'h00; cyc();
        both("p24_first", 1'b1, 3'd5, 3'd5);
        ack = 1'b1; cyc();
        both("p24_second", 1'b1, 3'd2, 3'd2);
        cyc();
        ack = 1'b0;
        both("p24_empty", 1'b0, 3'd0, 3'd0);
        chk("p24_idle", 32'(bus0.idle), 32'd1);

        // hold / no pre-emption
        req = 8'h04; cyc();
        req = 8'h00; cyc();
        both("hold_pres", 1'b1, 3'd2, 3'd2);
        req = 8'h80; cyc();
        req = 8'h00; cyc();
        both("hold_keep", 1'b1, 3'd2, 3'd2);
        chk("hold_pend", 32'(bus0.pend), 32'h84);
        ack = 1'b1; cyc();
        both("hold_next", 1'b1, 3'd7, 3'd7);
        cyc();
        ack = 1'b0;
        both("hold_done", 1'b0, 3'd0, 3'd0);

        // restart so the round-robin pointer is back at N-1
        rst_n = 1'b0; #1 rst_n = 1'b1;

        // all sources once, ack held: 7..0 on consecutive cycles
        req = 8'hFF; cyc();
        req = 8'h00; ack = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            cyc();
            both($sformatf("sweep%0d", i), 1'b1, 3'(i), 3'(i));
        end
        cyc();
        both("sweep_end", 1'b0, 3'd0, 3'd0);
        ack = 1'b0;

        // fairness: 7 re-pulsed in its own ack cycle alongside 6 and 3
        req = 8'hC8; cyc();
        req = 8'h00; cyc();
        both("fair_first", 1'b1, 3'd7, 3'd7);
        ack = 1'b1; req = 8'h80; cyc();
        req = 8'h00;
        both("fair_a", 1'b1, 3'd6, 3'd6);
        cyc();
        both("fair_b", 1'b1, 3'd7, 3'd3);
        cyc();
        both("fair_c", 1'b1, 3'd3, 3'd7);
        cyc();
        both("fair_end", 1'b0, 3'd0, 3'd0);
        ack = 1'b0;

        // masking keeps the bit pending; set wins over clear
        mask = 8'h80; req = 8'h80; cyc();
        req = 8'h00; cyc();
        both("mask_hid", 1'b0, 3'd0, 3'd0);
        chk("mask_idle", 32'(bus0.idle), 32'd0);
        chk("mask_pend", 32'(bus1.pend), 32'h80);
        mask = 8'h00; cyc();
        both("mask_clr", 1'b1, 3'd7, 3'd7);
        ack = 1'b1; req = 8'h80; cyc();
        ack = 1'b0; req = 8'h00;
        chk("swc_pend_fix", 32'(bus0.pend), 32'h80);
        chk("swc_pend_rr",  32'(bus1.pend), 32'h80);
        cyc();
        both("swc_repres", 1'b1, 3'd7, 3'd7);
        ack = 1'b1; cyc();
        ack = 1'b0;
        both("swc_end", 1'b0, 3'd0, 3'd0);

        // async reset mid-handshake
        req = 8'h0C; cyc();
        req = 8'h00; cyc();
        both("ar_pres", 1'b1, 3'd3, 3'd3);
        chk("ar_pend_pre", 32'(bus0.pend), 32'h0C);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus0.valid), 32'd0);
        chk("ar_pend",  32'(bus0.pend),  32'd0);
        chk("ar_idle",  32'(bus0.idle),  32'd1);
        chk("ar_id",    32'(bus0.id),    32'd0);
        chk("ar_rr_valid", 32'(bus1.valid), 32'd0);
        chk("ar_rr_pend",  32'(bus1.pend),  32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cyc();
        chk("ar_after_idle", 32'(bus1.idle), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
